// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared types and helpers for the LED pattern sequencer
//               and related blink blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    // Sequencer FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } led_state_e;

    // Default LED level when nothing is playing
    localparam logic LED_IDLE_LEVEL = 1'b0;

    // Terminal count of a 1 ms prescaler for a given clock frequency in Hz
    function automatic int unsigned tick_div(input int unsigned clock_frequency);
        return clock_frequency / 1000 - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_ms_tick.sv
`default_nettype none
// ============================================================================
// Module      : led_ms_tick
// Description : Millisecond prescaler. Counts 0..TICK_DIV and wraps; o_tick
//               is high in the terminal-count cycle. i_clear forces the count
//               back to zero so a new interval starts cycle-exact.
// Revision    : 1.0 - initial release
// ============================================================================
module led_ms_tick
    import led_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 27000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned TICK_DIV = tick_div(CLOCK_FREQUENCY);
    localparam int          CNT_W    = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_tick = (count_q == TICK_MAX);

    // Next count: clear has priority, otherwise wrap at terminal count
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (i_clear || o_tick) begin
            count_d = '0;
        end
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sequencer
// Description : Plays a programmable table of (level, duration-ms) steps on
//               Led_out after a Start pulse, then returns to IDLE_LEVEL.
//               Optional macro LED_SEQ_REPEAT_EN adds a Repeat input that
//               loops the pattern instead of finishing.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 27000000,
    parameter int          NUM_ENTRIES     = 8,
    parameter int          DUR_W           = 16,
    parameter logic        IDLE_LEVEL      = LED_IDLE_LEVEL,
    localparam int         IDX_W           = $clog2(NUM_ENTRIES)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Cfg_we,
    input  logic [IDX_W-1:0] Cfg_addr,
    input  logic             Cfg_level,
    input  logic [DUR_W-1:0] Cfg_duration,
`ifdef LED_SEQ_REPEAT_EN
    input  logic             Repeat,
`endif
    output logic             Busy,
    output logic             Done,
    output logic             Led_out,
    output logic             Tick_ms
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    led_state_e       state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [DUR_W-1:0] remaining_q, remaining_d;
    logic             led_q, led_d;

    // Pattern table: MSB is the level, low bits are the duration
    logic [DUR_W:0]   pattern_q [NUM_ENTRIES];
    logic [DUR_W:0]   entry_rd;
    logic             repeat_req;

`ifdef LED_SEQ_REPEAT_EN
    assign repeat_req = Repeat;
`else
    assign repeat_req = 1'b0;
`endif

    assign entry_rd = pattern_q[index_q];
    assign Busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign Done     = (state_q == ST_DONE);
    assign Led_out  = led_q;

    // Prescaler restarts in every LOAD so each step starts on a fresh ms
    led_ms_tick #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_ms_tick (
        .clk     (Clock),
        .rst     (Reset),
        .i_clear (state_q == ST_LOAD),
        .o_tick  (Tick_ms)
    );

    // Table writes are only honoured while idle; contents are never reset
    always_ff @(posedge Clock) begin
        if (Cfg_we && (state_q == ST_IDLE)) begin
            pattern_q[Cfg_addr] <= {Cfg_level, Cfg_duration};
        end
    end

    // Next-state, step index, remaining time and LED level
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        remaining_d = remaining_q;
        led_d       = led_q;
        case (state_q)
            ST_IDLE: begin
                led_d = IDLE_LEVEL;
                if (Start) begin
                    state_d = ST_LOAD;
                    index_d = '0;
                end
            end
            ST_LOAD: begin
                if (entry_rd[DUR_W-1:0] == '0) begin
                    if (repeat_req) begin
                        index_d = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    led_d       = entry_rd[DUR_W];
                    remaining_d = entry_rd[DUR_W-1:0];
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Tick_ms) begin
                    remaining_d = remaining_q - DUR_W'(1);
                    if (remaining_q == DUR_W'(1)) begin
                        if (index_q != LAST_IDX) begin
                            index_d = index_q + IDX_W'(1);
                            state_d = ST_LOAD;
                        end else if (repeat_req) begin
                            index_d = '0;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                led_d   = IDLE_LEVEL;
                state_d = ST_IDLE;
            end
            default: begin
                led_d   = IDLE_LEVEL;
                state_d = ST_IDLE;
            end
        endcase
        // Stop aborts from anywhere and beats a simultaneous Start
        if (Stop) begin
            state_d = ST_IDLE;
            led_d   = IDLE_LEVEL;
        end
    end

    // Control registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            remaining_q <= '0;
            led_q       <= IDLE_LEVEL;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            remaining_q <= remaining_d;
            led_q       <= led_d;
        end
    end

endmodule
`default_nettype wire
